// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by the key schedule and the round datapath stages.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [31:0] aes_word_t;
    typedef aes_word_t [3:0] aes_key_t;

    typedef enum logic {
        IDLE,
        EMIT
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_sched_stage_if.sv
// Key-in and round-key-out valid/ready channels of the key schedule.
// The slave modport is the stage view; master is the driver view.
interface aes128_key_sched_stage_if;
    import aes_pkg::*;

    logic                  key_valid;
    logic                  key_ready;
    logic [AES_KW-1:0]     key_in;
    logic                  rk_valid;
    logic                  rk_ready;
    logic [AES_KW-1:0]     rk_out;
    logic [3:0]            rk_round;
    logic                  busy;

    modport master (
        output key_valid,
        output key_in,
        output rk_ready,
        input  key_ready,
        input  rk_valid,
        input  rk_out,
        input  rk_round,
        input  busy
    );

    modport slave (
        input  key_valid,
        input  key_in,
        input  rk_ready,
        output key_ready,
        output rk_valid,
        output rk_out,
        output rk_round,
        output busy
    );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Table is packed so that entry 0 sits in the top byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ~a * 8 selects entry a counted from the MSB end
    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes128_key_sched_stage.sv
// AES-128 key expansion: accepts a cipher key, then streams
// round keys 0..10 one per handshake with full backpressure.
module aes128_key_sched_stage
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input logic                     clk,
    input logic                     rst,
    aes128_key_sched_stage_if.slave ks
);

    ks_state_t       state;
    ks_state_t       state_n;
    logic [7:0]      rcon;
    logic [KW-1:0]   rk_q;
    logic [3:0]      round_q;

    aes_word_t       w0, w1, w2, w3;
    aes_word_t       rot, sub, t;
    aes_word_t       n0, n1, n2, n3;

    logic            key_fire;
    logic            rk_fire;
    logic            last;

    assign key_fire = ks.key_valid && (state == IDLE);
    assign rk_fire  = ks.rk_ready && (state == EMIT);
    assign last     = (round_q == 4'(NR));

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[g*8 +: 8]),
            .y (sub[g*8 +: 8])
        );
    end

    assign t  = sub ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (key_fire) state_n = EMIT;
            EMIT: if (rk_fire && last) state_n = IDLE;
        endcase
    end

    // rcon for round 10 is consumed at the 9->10 step, so it stops at 8'h36
    always_ff @(posedge clk) begin
        if (rst) begin
            rcon    <= RCON_INIT;
            rk_q    <= '0;
            round_q <= '0;
        end else if (key_fire) begin
            rcon    <= RCON_INIT;
            rk_q    <= ks.key_in;
            round_q <= '0;
        end else if (rk_fire && !last) begin
            rk_q    <= {n0, n1, n2, n3};
            round_q <= round_q + 4'd1;
            if (round_q != 4'(NR - 1)) begin
                rcon <= xtime(rcon);
            end
        end
    end

    assign ks.key_ready = (state == IDLE);
    assign ks.rk_valid  = (state == EMIT);
    assign ks.busy      = (state == EMIT);
    assign ks.rk_out    = rk_q;
    assign ks.rk_round  = round_q;

endmodule

// File: doc/aes128_key_sched_stage.md
Name: aes128_key_sched_stage

Overview:
- Sequential AES-128 key-expansion stage. Issues one 128-bit round key per handshake.
- Sits directly upstream of the AddRoundKey/round-combinational cones. It supplies the round-key bits those cones XOR against state.
- Accepts a cipher key over a valid/ready input, then streams round keys 0..10 over a valid/ready output.

Parameters:
- NR, 10, number of rounds. AES-128 only; any other value is illegal. Round counter width is fixed at 4.
- KW, 128, key/round-key width. Fixed; present for readability only.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_valid  input  1  cipher key offered.
- key_ready  output  1  stage can accept a key.
- key_in  input  128  cipher key. w0 = key_in[127:96], w3 = key_in[31:0].
- rk_valid  output  1  round key on rk_out is valid.
- rk_ready  input  1  downstream consumes the round key.
- rk_out  output  128  current round key; same word order as key_in.
- rk_round  output  4  round index of rk_out, 0..10.
- busy  output  1  expansion in progress (not IDLE).

Behaviour:
- Reset values, applied on the clock edge where rst=1:
  - key_ready=1, rk_valid=0, rk_out=0, rk_round=0, busy=0.
  - Internal state: rcon=8'h01, FSM=IDLE.
- States: IDLE, EMIT.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&key_ready, latch key_in into rk_out, set rk_round=0, rcon=8'h01, go to EMIT.
  - rk_valid=1 on the next cycle, giving 1 cycle latency from key acceptance.
- EMIT:
  - key_ready=0, rk_valid=1, busy=1.
  - rk_out and rk_round hold stable while rk_ready=0 (full backpressure, no bubbles).
  - On rk_valid&rk_ready with rk_round<10:
    - Load the next round key, rk_round+1.
    - Advance rcon: xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
    - Sequence: 01,02,04,08,10,20,40,80,1b,36.
    - Stay in EMIT. The next key is valid the following cycle, so one key per cycle is sustained under rk_ready=1.
  - On rk_valid&rk_ready with rk_round==10:
    - Go to IDLE, rk_valid=0 next cycle, key_ready=1 next cycle.
    - The transfer cycle itself does not accept a key, because key_ready is still 0 then.
- Next-key arithmetic, with w0..w3 the current key words:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the AES S-box to each byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Purely combinational from registered state. Exactly 4 S-box instances.
- Boundaries:
  - key_valid while busy is ignored. No drop and no corruption of the stream; the source must hold key_valid.
  - key_in changing while key_valid=0 has no effect.
  - rst asserted mid-expansion: stream is abandoned, all outputs take reset values on that edge, and no partial key is flagged valid.
  - rst has priority over any simultaneous handshake.
  - rk_round never exceeds 10 and rcon never advances past 8'h36.
- No combinational path from key_valid to key_ready, or from rk_ready to rk_valid.

Decomposition:
- Shared package aes_pkg holds:
  - Constants AES_NR=10, AES_KW=128.
  - RCON_INIT=8'h01, RCON_POLY=8'h1b.
  - Typedef aes_word_t (32 bits) and aes_key_t (4 x aes_word_t).
  - State enum {IDLE, EMIT}.
  - Function xtime.
- One sub-module: aes_sbox, a combinational 8-bit forward S-box, instantiated 4 times. The team reuses it in the SubBytes stage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 ->
  - rk_round 0 = key, round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, on 11 consecutive cycles.
  - key_ready returns to 1 one cycle after round 10.
- All-zero key -> round 1 = 62636363626363636263636362636363. rcon reaches 8'h36 at the round-10 transfer.
- Random rk_ready toggling on the FIPS key -> identical 11-key sequence. rk_out and rk_round stable whenever rk_valid&!rk_ready.
- key_valid held high with a different key during EMIT -> key_ready=0 and the stream is unaffected. The second key is accepted one cycle after round 10 transfers.
- rst=1 at rk_round=5 -> next cycle rk_valid=0, key_ready=1, rk_out=0. A fresh key then produces round 1 correctly (rcon restarted at 01).
- Back-to-back keys, second key_valid held continuously -> at most one idle cycle between round 10 of key A and round 0 of key B.
